// File: rtl/txchar.sv
// Free-running 8N1 UART transmitter: sends CHAR back to back forever.
// Includes its own baud tick; tx comes straight from a flop.
module txchar #(
  parameter int unsigned BAUDDIV = 104,
  parameter logic [7:0]  CHAR    = 8'h4B
) (
  input  logic clk,
  input  logic rstn,
  output logic tx
);

  localparam int unsigned CW = $clog2(BAUDDIV);
  localparam logic [CW-1:0] LAST = CW'(BAUDDIV - 1);
  localparam logic [9:0] FRAME = {1'b1, CHAR, 1'b0};

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [9:0]    shreg_q;
  logic          tick;

  assign tick = (cnt_q == LAST);

  // tx is a copy of shreg_q[0] one clock later, so the frame loaded on
  // leaving IDLE first shows on the pin at the second edge after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '1;
      tx      <= 1'b1;
    end else begin
      tx <= shreg_q[0];
      if (state_q != StIdle) begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          state_q <= StStart;
          shreg_q <= FRAME;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
        StStart: begin
          if (tick) begin
            state_q <= StData;
            idx_q   <= '0;
            shreg_q <= {1'b1, shreg_q[9:1]};
          end
        end
        StData: begin
          if (tick) begin
            idx_q   <= idx_q + 3'd1;
            shreg_q <= {1'b1, shreg_q[9:1]};
            if (idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end
        end
        StStop: begin
          if (tick) begin
            state_q <= StStart;
            shreg_q <= FRAME;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_txchar.sv
// Directed bench for txchar: reset, frame shape/timing, back-to-back frames,
// mid-frame reset, short reset pulse, and several BAUDDIV/CHAR settings.
module tb_txchar;

  logic       clk;
  logic [5:0] rstv;
  logic [5:0] txv;

  int n_assert;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  txchar #(.BAUDDIV(4),               .CHAR(8'h4B)) u0 (.clk(clk), .rstn(rstv[0]), .tx(txv[0]));
  txchar                                             u1 (.clk(clk), .rstn(rstv[1]), .tx(txv[1]));
  txchar #(.BAUDDIV(4),               .CHAR(8'h00)) u2 (.clk(clk), .rstn(rstv[2]), .tx(txv[2]));
  txchar #(.BAUDDIV(4),               .CHAR(8'hFF)) u3 (.clk(clk), .rstn(rstv[3]), .tx(txv[3]));
  txchar #(.BAUDDIV(2),               .CHAR(8'h4B)) u4 (.clk(clk), .rstn(rstv[4]), .tx(txv[4]));
  txchar #(.BAUDDIV(104),             .CHAR(8'h00)) u5 (.clk(clk), .rstn(rstv[5]), .tx(txv[5]));

  task automatic chk(input logic obs, input logic exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: tx=%b expected %b", tag, obs, exp);
    end
  endtask

  // Release one DUT at a negedge and check the single idle clock.
  task automatic release_dut(input int idx);
    rstv[idx] = 1'b1;
    @(negedge clk);
    chk(txv[idx], 1'b1, $sformatf("dut%0d idle clock", idx));
  endtask

  // Check the first 'limit' negedge samples of a frame {1,ch,0}, LSB first.
  task automatic check_frame(input int idx, input int div, input logic [7:0] ch,
                             input int limit, input string tag);
    logic [9:0] fr;
    int         n;
    fr = {1'b1, ch, 1'b0};
    n  = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < div; j++) begin
        if (n < limit) begin
          @(negedge clk);
          chk(txv[idx], fr[k], $sformatf("%s dut%0d bit%0d cyc%0d", tag, idx, k, j));
          n++;
        end
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rstv     = '0;

    // Reset held for 5 clocks: every line idles high.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) chk(txv[i], 1'b1, $sformatf("reset hold dut%0d", i));
    end

    // First frame plus two more, back to back (3 x 40 clocks).
    release_dut(0);
    for (int f = 0; f < 3; f++) check_frame(0, 4, 8'h4B, 40, $sformatf("cont f%0d", f));

    // Mid-frame reset during data bit 3: 4 start + 3*4 data + 2 samples.
    rstv[0] = 1'b0;
    @(negedge clk);
    release_dut(0);
    check_frame(0, 4, 8'h4B, 18, "pre-abort");
    #2 rstv[0] = 1'b0;
    #1 chk(txv[0], 1'b1, "async reset bit3");
    @(negedge clk);
    chk(txv[0], 1'b1, "held reset");
    release_dut(0);
    check_frame(0, 4, 8'h4B, 40, "after abort");

    // Abort again while tx is low (data bit 4) to see the async path act.
    check_frame(0, 4, 8'h4B, 22, "pre-abort2");
    #2 rstv[0] = 1'b0;
    #1 chk(txv[0], 1'b1, "async reset bit4");
    @(negedge clk);

    // One-cycle release pulse: tx must never leave 1.
    rstv[0] = 1'b1;
    @(negedge clk);
    chk(txv[0], 1'b1, "short pulse high");
    rstv[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk(txv[0], 1'b1, "short pulse after");
    end

    // CHAR extremes at BAUDDIV=4.
    release_dut(2);
    check_frame(2, 4, 8'h00, 40, "char00");
    release_dut(3);
    check_frame(3, 4, 8'hFF, 40, "charFF");

    // BAUDDIV=2, three frames.
    release_dut(4);
    for (int f = 0; f < 3; f++) check_frame(4, 2, 8'h4B, 20, $sformatf("div2 f%0d", f));

    // Default BAUDDIV=104: 1040-clock frames, then the next start bit.
    release_dut(1);
    check_frame(1, 104, 8'h4B, 1040, "div104");
    @(negedge clk);
    chk(txv[1], 1'b0, "div104 next start");
    release_dut(5);
    check_frame(5, 104, 8'h00, 1040, "div104 char00");
    @(negedge clk);
    chk(txv[5], 1'b0, "div104 char00 next start");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
